// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch unit.
//   - fetch_state_e : fetch FSM state encoding (idle / request / hold / error)
//   - *_DEF         : default widths, reset PC and wait-state timeout
//   - OPCODE_MSB/LSB: opcode field position inside the instruction register
package fetch_pkg;

   localparam int unsigned ADDR_W_DEF      = 16;
   localparam int unsigned DATA_W_DEF      = 16;
   localparam int unsigned RESET_PC_DEF    = 0;
   localparam int unsigned TIMEOUT_CYC_DEF = 15;

   localparam int unsigned OPCODE_MSB = 15;
   localparam int unsigned OPCODE_LSB = 12;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StHold = 2'd2,
      StErr  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read channel between the fetch unit and memory.
//   mem_req   : read request, held while waiting for data
//   mem_addr  : request address, stable while mem_req=1
//   mem_ack   : read data valid this cycle (may coincide with the first mem_req cycle)
//   mem_rdata : read data, meaningful only when mem_ack=1
// Modports: master (fetch unit side), slave (memory side).
interface fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/fetch_wdog.sv
// fetch_wdog: wait-state watchdog for the fetch request.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_req       : fetch FSM is in the request state
//   ack          : memory acknowledged this cycle
//   expired      : this is the TIMEOUT_CYC-th consecutive request cycle without ack
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_wdog #(
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_req,
   input  logic ack,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

   logic [CntW-1:0] count_q, count_d;

   // Held at zero outside the request state, so every new request starts from zero.
   always_comb begin
      count_d = count_q;
      if (!in_req) begin
         count_d = '0;
      end else if (!ack) begin
         count_d = count_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Fires on the cycle whose increment would bring the count to TIMEOUT_CYC.
   assign expired = in_req && !ack && (count_q == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch datapath feeding the control unit.
// Owns the PC, the memory request handshake, a one-word fetch buffer and the IR.
//   clk, reset_n : clock, asynchronous active-low reset
//   PC_enable    : start a fetch at the current PC (honoured only when idle)
//   PC_load      : redirect the PC to target_addr
//   target_addr  : branch/jump target
//   IR_load      : move the fetched word into IR
//   mem          : instruction-memory read channel (fetch_unit_if.master)
//   IR, PC       : instruction register, program counter
//   opcode       : IR[15:12] back to the control unit
//   fetch_busy   : request outstanding or IR_load pending
//   fetch_valid  : fetch buffer holds an unconsumed word
//   fetch_err    : sticky wait-state timeout error
// Build option: define FETCH_TIMEOUT_EN to add the wait-state watchdog and the error
// state; otherwise a request waits for ack indefinitely and fetch_err is tied low.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned RESET_PC = RESET_PC_DEF
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             PC_enable,
   input  logic                             PC_load,
   input  logic [ADDR_W-1:0]                target_addr,
   input  logic                             IR_load,
   fetch_unit_if.master                     mem,
   output logic [DATA_W-1:0]                IR,
   output logic [ADDR_W-1:0]                PC,
   output logic [OPCODE_MSB-OPCODE_LSB:0]   opcode,
   output logic                             fetch_busy,
   output logic                             fetch_valid,
   output logic                             fetch_err
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] fbuf_q, fbuf_d;
   logic              valid_q, valid_d;
   logic              pending_q, pending_d;
   logic              squash_q, squash_d;

`ifdef FETCH_TIMEOUT_EN
   logic err_q, err_d;
   logic expired;

   fetch_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk     (clk),
      .reset_n (reset_n),
      .in_req  (state_q == StReq),
      .ack     (mem.mem_ack),
      .expired (expired)
   );
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      ir_d       = ir_q;
      fbuf_d     = fbuf_q;
      valid_d    = valid_q;
      pending_d  = pending_q;
      squash_d   = squash_q;
`ifdef FETCH_TIMEOUT_EN
      err_d      = err_q;
`endif

      unique case (state_q)
         StIdle: begin
            // Redirect beats a fetch start in the same cycle.
            if (PC_load) begin
               pc_d = target_addr;
            end else if (PC_enable) begin
               req_addr_d = pc_q;
               state_d    = StReq;
            end
         end

         StReq: begin
            if (PC_load) begin
               // A request in flight cannot be withdrawn: mark its data for discard.
               // If the ack lands on this very cycle the data is simply dropped.
               pc_d      = target_addr;
               pending_d = 1'b0;
               if (mem.mem_ack) begin
                  squash_d = 1'b0;
                  state_d  = StIdle;
               end else begin
                  squash_d = 1'b1;
               end
            end else if (mem.mem_ack) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = StIdle;
               end else begin
                  pc_d = pc_q + ADDR_W'(1);
                  if (IR_load || pending_q) begin
                     ir_d      = mem.mem_rdata;
                     pending_d = 1'b0;
                     state_d   = StIdle;
                  end else begin
                     fbuf_d  = mem.mem_rdata;
                     valid_d = 1'b1;
                     state_d = StHold;
                  end
               end
`ifdef FETCH_TIMEOUT_EN
            end else if (expired) begin
               err_d     = 1'b1;
               pending_d = 1'b0;
               squash_d  = 1'b0;
               state_d   = StErr;
`endif
            end else if (IR_load && !squash_q) begin
               // Remember an early IR_load so the word goes straight to IR on ack.
               pending_d = 1'b1;
            end
         end

         StHold: begin
            if (IR_load) begin
               ir_d = fbuf_q;
            end
            if (PC_load) begin
               pc_d = target_addr;
            end
            if (IR_load || PC_load) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end

         StErr: begin
`ifdef FETCH_TIMEOUT_EN
            if (PC_load) begin
               pc_d    = target_addr;
               err_d   = 1'b0;
               state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         pc_q       <= ADDR_W'(RESET_PC);
         req_addr_q <= '0;
         ir_q       <= '0;
         fbuf_q     <= '0;
         valid_q    <= 1'b0;
         pending_q  <= 1'b0;
         squash_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         ir_q       <= ir_d;
         fbuf_q     <= fbuf_d;
         valid_q    <= valid_d;
         pending_q  <= pending_d;
         squash_q   <= squash_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign fetch_err = err_q;
`else
   assign fetch_err = 1'b0;
`endif

   assign mem.mem_req  = (state_q == StReq);
   assign mem.mem_addr = req_addr_q;
   assign IR           = ir_q;
   assign PC           = pc_q;
   assign opcode       = ir_q[OPCODE_MSB:OPCODE_LSB];
   assign fetch_busy   = (state_q == StReq) || pending_q;
   assign fetch_valid  = valid_q;

endmodule
